// File: rtl/gpr_dump_pkg.sv
// Shared definitions for the GPR dump serializer: state encoding and byte constants.
// Latency: n/a (types, constants and a byte-select helper only).
// Backpressure: n/a.
package gpr_dump_pkg;

   // HDR is only reachable when GPR_DUMP_HEADER_EN is defined.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_SEND  = 3'd2,
      ST_DONE  = 3'd3,
      ST_HDR   = 3'd4
   } dump_state_t;

   localparam logic [7:0] HDR_MAGIC      = 8'hA5;
   localparam int         BYTES_PER_WORD = 4;

   // Little-endian byte select: index 0 is bits 7:0.
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      return w[8*idx +: 8];
   endfunction

endpackage

// File: rtl/gpr_dump.sv
// Dumps registers FIRST_REG..LAST_REG of a register file as a little-endian byte stream.
// Latency: start to first byte 2 cycles (1 with the header); 5 cycles per word at full rate.
// Backpressure: tx_valid/tx_ready; tx_data/tx_valid are registered and held while stalled.
//
// Ports: clk, rst (sync, active-high); start (sampled in IDLE only); rd_addr/rd_data
// combinational register-file read port; tx_data/tx_valid/tx_ready byte stream;
// busy (high outside IDLE); done (one-cycle pulse at completion).
// Build option: define GPR_DUMP_HEADER_EN to prefix the dump with 0xA5 and the word count.
module gpr_dump #(
   parameter int FIRST_REG = 1,
   parameter int LAST_REG  = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [4:0]  rd_addr,
   input  logic [31:0] rd_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done
);
   import gpr_dump_pkg::*;

   dump_state_t state;
   logic [31:0] snapshot;
   logic [1:0]  idx;
`ifdef GPR_DUMP_HEADER_EN
   logic        hdr_idx;
`endif

   logic xfer;
   assign xfer = tx_valid && tx_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         rd_addr  <= 5'd0;
         snapshot <= 32'd0;
         idx      <= 2'd0;
         tx_valid <= 1'b0;
         tx_data  <= 8'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef GPR_DUMP_HEADER_EN
         hdr_idx  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy    <= 1'b1;
                  rd_addr <= 5'(FIRST_REG);
`ifdef GPR_DUMP_HEADER_EN
                  state    <= ST_HDR;
                  hdr_idx  <= 1'b0;
                  tx_valid <= 1'b1;
                  tx_data  <= HDR_MAGIC;
`else
                  state    <= ST_FETCH;
`endif
               end
            end

            // The word is frozen here so later register-file writes cannot tear it.
            ST_FETCH: begin
               snapshot <= rd_data;
               idx      <= 2'd0;
               tx_data  <= rd_data[7:0];
               tx_valid <= 1'b1;
               state    <= ST_SEND;
            end

            ST_SEND: begin
               if (xfer) begin
                  if (idx == 2'(BYTES_PER_WORD - 1)) begin
                     tx_valid <= 1'b0;
                     if (rd_addr != 5'(LAST_REG)) begin
                        rd_addr <= rd_addr + 5'd1;
                        state   <= ST_FETCH;
                     end else begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                     end
                  end else begin
                     idx     <= idx + 2'd1;
                     tx_data <= word_byte(snapshot, idx + 2'd1);
                  end
               end
            end

            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

`ifdef GPR_DUMP_HEADER_EN
            ST_HDR: begin
               if (xfer) begin
                  if (!hdr_idx) begin
                     hdr_idx <= 1'b1;
                     tx_data <= 8'(LAST_REG - FIRST_REG + 1);
                  end else begin
                     tx_valid <= 1'b0;
                     state    <= ST_FETCH;
                  end
               end
            end
`endif

            default: begin
               state    <= ST_IDLE;
               tx_valid <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule
